// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port (CE/WE/RE/BE/READY handshake)
// between the CPU fetch port (I) and the load/store port (D).
// A grant is registered in IDLE; the winning request is latched into the
// MEM_* registers and held for the whole BUSY state. Completion (MEM_READY)
// or a per-transaction timeout returns a one-cycle Ready pulse to the owner.
// Optional build macro: ARB_ROUND_ROBIN_EN selects alternating arbitration
// on ties instead of fixed D priority with the D-streak starvation guard.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,   // 1..15, fixed-priority mode only
    parameter int unsigned TIMEOUT      = 64   // 0 disables, max 255
) (
    input  logic        clk,
    input  logic        reset,
    // fetch port
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic [31:0] IData,
    output logic        IReady,
    // load/store port
    input  logic [31:0] DPC,
    input  logic [31:0] DAddr,
    input  logic        DREn,
    input  logic        DWEn,
    input  logic [3:0]  DByteEn,
    input  logic [31:0] DWData,
    output logic [31:0] DRData,
    output logic        DReady,
    // shared memory port
    output logic [31:0] MEM_PC,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_CE,
    output logic        MEM_WE,
    output logic        MEM_RE,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_DIN,
    input  logic [31:0] MEM_DOUT,
    input  logic        MEM_READY,
    output logic        BUS_ERR
);

    localparam int unsigned TCNT_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic             TIMEOUT_EN = (TIMEOUT != 0);
    // TIMEOUT=0 wraps here but is masked by TIMEOUT_EN
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
    localparam logic [TCNT_W-1:0] TCNT_SAT  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t            state;
    logic [TCNT_W-1:0] tcnt;

    logic d_req;
    logic grant_d;
    logic grant_i;
    logic busy;
    logic done_ok;
    logic timeout_hit;
    logic finish;

    // Request decode and completion/timeout conditions for the current BUSY cycle
    always_comb begin
        d_req       = DREn | DWEn;
        busy        = (state == ST_BUSY_I) || (state == ST_BUSY_D);
        done_ok     = busy & MEM_READY;
        timeout_hit = busy & ~MEM_READY & TIMEOUT_EN & (tcnt == TCNT_LAST);
        finish      = done_ok | timeout_hit;
    end

`ifdef ARB_ROUND_ROBIN_EN
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    grant_t last_grant;

    // Ties alternate; a single pending requester always wins
    always_comb begin
        grant_d = d_req;
        if (d_req && IReq) begin
            grant_d = (last_grant == GRANT_I);
        end
        grant_i = IReq & ~grant_d;
    end

    // Remember the most recent winner to break the next tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_I;
        end else if (state == ST_IDLE) begin
            if (grant_d) begin
                last_grant <= GRANT_D;
            end else if (grant_i) begin
                last_grant <= GRANT_I;
            end
        end
    end
`else
    localparam int unsigned        STREAK_W   = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_SAT = '1;

    logic [STREAK_W-1:0] d_streak;
    logic                i_starved;

    // D has priority unless I has waited through MAX_D_STREAK D grants
    always_comb begin
        i_starved = IReq && (d_streak == STREAK_MAX);
        grant_d   = d_req & ~i_starved;
        grant_i   = IReq & ~grant_d;
    end

    // Count consecutive D grants taken while I was waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_streak <= '0;
        end else if (state == ST_IDLE) begin
            if (grant_d) begin
                if (!IReq) begin
                    d_streak <= '0;
                end else if (d_streak != STREAK_SAT) begin
                    d_streak <= d_streak + STREAK_W'(1);
                end
            end else if (grant_i) begin
                d_streak <= '0;
            end
        end
    end
`endif

    // Grant/complete sequencing with the latched memory-port request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tcnt     <= '0;
            MEM_PC   <= '0;
            MEM_ADDR <= '0;
            MEM_CE   <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_RE   <= 1'b0;
            MEM_BE   <= '0;
            MEM_DIN  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tcnt <= '0;
                    if (grant_d) begin
                        state    <= ST_BUSY_D;
                        MEM_PC   <= DPC;
                        MEM_ADDR <= DAddr;
                        MEM_CE   <= 1'b1;
                        // simultaneous read+write is treated as a write
                        MEM_WE   <= DWEn;
                        MEM_RE   <= DREn & ~DWEn;
                        MEM_BE   <= DByteEn;
                        MEM_DIN  <= DWData;
                    end else if (grant_i) begin
                        state    <= ST_BUSY_I;
                        MEM_PC   <= '0;
                        MEM_ADDR <= IAddr;
                        MEM_CE   <= 1'b1;
                        MEM_WE   <= 1'b0;
                        MEM_RE   <= 1'b1;
                        MEM_BE   <= '1;
                        MEM_DIN  <= '0;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (finish) begin
                        state    <= ST_IDLE;
                        tcnt     <= '0;
                        MEM_PC   <= '0;
                        MEM_ADDR <= '0;
                        MEM_CE   <= 1'b0;
                        MEM_WE   <= 1'b0;
                        MEM_RE   <= 1'b0;
                        MEM_BE   <= '0;
                        MEM_DIN  <= '0;
                    end else if (tcnt != TCNT_SAT) begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tcnt   <= '0;
                    MEM_CE <= 1'b0;
                    MEM_WE <= 1'b0;
                    MEM_RE <= 1'b0;
                end
            endcase
        end
    end

    // Same-cycle Ready/data return to the owning port; data is 0 on timeout
    always_comb begin
        IReady  = 1'b0;
        DReady  = 1'b0;
        IData   = '0;
        DRData  = '0;
        BUS_ERR = timeout_hit;
        if (state == ST_BUSY_I) begin
            IReady = finish;
            IData  = done_ok ? MEM_DOUT : DATA_W'(0);
        end
        if (state == ST_BUSY_D) begin
            DReady = finish;
            DRData = done_ok ? MEM_DOUT : DATA_W'(0);
        end
    end

    // Byte-enable width ties the latched register to the port width
    if (BE_W != 4) begin : g_be_width_guard
        // unreachable: the port is fixed at four byte lanes
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned TO   = 64;
    localparam int unsigned MAXS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] DPC, DAddr, DWData;
    logic        DREn, DWEn;
    logic [3:0]  DByteEn;
    logic [31:0] MEM_DOUT;
    logic        MEM_READY;

    logic [31:0] IData, DRData, MEM_PC, MEM_ADDR, MEM_DIN;
    logic        IReady, DReady, MEM_CE, MEM_WE, MEM_RE, BUS_ERR;
    logic [3:0]  MEM_BE;

    logic [31:0] nt_IData, nt_DRData, nt_MEM_PC, nt_MEM_ADDR, nt_MEM_DIN;
    logic        nt_IReady, nt_DReady, nt_MEM_CE, nt_MEM_WE, nt_MEM_RE, nt_BUS_ERR;
    logic [3:0]  nt_MEM_BE;

    mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAddr(IAddr), .IData(IData), .IReady(IReady),
        .DPC(DPC), .DAddr(DAddr), .DREn(DREn), .DWEn(DWEn), .DByteEn(DByteEn),
        .DWData(DWData), .DRData(DRData), .DReady(DReady),
        .MEM_PC(MEM_PC), .MEM_ADDR(MEM_ADDR), .MEM_CE(MEM_CE), .MEM_WE(MEM_WE),
        .MEM_RE(MEM_RE), .MEM_BE(MEM_BE), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT),
        .MEM_READY(MEM_READY), .BUS_ERR(BUS_ERR)
    );

    // Second instance with the timeout disabled, fed the same stimulus
    mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(0)) dut_nt (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAddr(IAddr), .IData(nt_IData), .IReady(nt_IReady),
        .DPC(DPC), .DAddr(DAddr), .DREn(DREn), .DWEn(DWEn), .DByteEn(DByteEn),
        .DWData(DWData), .DRData(nt_DRData), .DReady(nt_DReady),
        .MEM_PC(nt_MEM_PC), .MEM_ADDR(nt_MEM_ADDR), .MEM_CE(nt_MEM_CE), .MEM_WE(nt_MEM_WE),
        .MEM_RE(nt_MEM_RE), .MEM_BE(nt_MEM_BE), .MEM_DIN(nt_MEM_DIN), .MEM_DOUT(MEM_DOUT),
        .MEM_READY(MEM_READY), .BUS_ERR(nt_BUS_ERR)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference: which master owns the port and what it asked for
    bit          m_busy, m_own_d, m_we, m_re, m_last_d;
    logic [31:0] m_addr, m_din, m_pc;
    logic [3:0]  m_be;
    int          m_wait, m_streak;

    // Random-phase masters and two memory images (device side and reference side)
    bit          rand_mode, i_pend, d_pend;
    logic [31:0] mem_dev [16];
    logic [31:0] mem_ref [16];

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic model_clear();
        m_busy = 0; m_own_d = 0; m_we = 0; m_re = 0; m_last_d = 0;
        m_addr = '0; m_din = '0; m_pc = '0; m_be = '0; m_wait = 0; m_streak = 0;
    endtask

    // Check this cycle's outputs against the reference, then advance one clock
    task automatic cyc();
        bit rdy_now, to_now, fin, dreq, pick_d;
        #1;
        rdy_now = m_busy && MEM_READY;
        to_now  = m_busy && !MEM_READY && (TO != 0) && (m_wait == int'(TO) - 1);
        fin     = rdy_now || to_now;
        ck("mem_ce",   32'(MEM_CE),   32'(m_busy));
        ck("mem_addr", MEM_ADDR,      m_busy ? m_addr : 32'h0);
        ck("mem_be",   32'(MEM_BE),   m_busy ? 32'(m_be) : 32'h0);
        ck("mem_din",  MEM_DIN,       m_busy ? m_din : 32'h0);
        ck("mem_pc",   MEM_PC,        m_busy ? m_pc : 32'h0);
        ck("mem_we",   32'(MEM_WE),   32'(m_busy && m_we));
        ck("mem_re",   32'(MEM_RE),   32'(m_busy && m_re));
        ck("i_ready",  32'(IReady),   32'(m_busy && !m_own_d && fin));
        ck("d_ready",  32'(DReady),   32'(m_busy && m_own_d && fin));
        ck("bus_err",  32'(BUS_ERR),  32'(to_now));
        if (fin && !m_own_d) ck("i_data", IData,  to_now ? 32'h0 : MEM_DOUT);
        if (fin &&  m_own_d) ck("d_data", DRData, to_now ? 32'h0 : MEM_DOUT);
        if (rand_mode) begin
            if (MEM_CE && MEM_READY && MEM_WE)
                mem_dev[MEM_ADDR[5:2]] = merge(mem_dev[MEM_ADDR[5:2]], MEM_DIN, MEM_BE);
            if (rdy_now) begin
                if (!m_own_d) ck("fetch_sb", IData, mem_ref[m_addr[5:2]]);
                else if (m_re) ck("load_sb", DRData, mem_ref[m_addr[5:2]]);
                if (m_own_d && m_we)
                    mem_ref[m_addr[5:2]] = merge(mem_ref[m_addr[5:2]], m_din, m_be);
            end
            if (fin) begin
                if (m_own_d) d_pend = 0;
                else         i_pend = 0;
            end
        end
        dreq = DREn || DWEn;
        if (m_busy) begin
            if (fin) m_busy = 0;
            else     m_wait++;
        end else if (IReq || dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_d   = (dreq && IReq) ? !m_last_d : dreq;
            m_last_d = pick_d;
`else
            pick_d = dreq && !(IReq && m_streak == int'(MAXS));
            if (pick_d && IReq) m_streak = (m_streak < 15) ? m_streak + 1 : 15;
            else                m_streak = 0;
`endif
            m_busy = 1; m_own_d = pick_d; m_wait = 0;
            if (pick_d) begin
                m_addr = DAddr; m_be = DByteEn; m_din = DWData; m_pc = DPC;
                m_we = DWEn; m_re = DREn && !DWEn;
            end else begin
                m_addr = IAddr; m_be = 4'hF; m_din = '0; m_pc = '0;
                m_we = 0; m_re = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        IReq = 0; DREn = 0; DWEn = 0; MEM_READY = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        idle_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    logic exp_order [10];
    int   idx;
    bit   nt_bad;
    int   kind;

    initial begin
        reset = 1; IAddr = '0; DPC = '0; DAddr = '0; DByteEn = '0; DWData = '0; MEM_DOUT = '0;
        idle_inputs();
        model_clear();
        rand_mode = 0; i_pend = 0; d_pend = 0;
        for (int i = 0; i < 16; i++) begin
            mem_dev[i] = $urandom;
            mem_ref[i] = mem_dev[i];
        end
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 10; i++) exp_order[i] = (i % 2 == 0);
`else
        for (int i = 0; i < 10; i++) exp_order[i] = (i % 5 != 4);
`endif

        // reset state
        repeat (2) @(negedge clk);
        #1;
        ck("rst_ce",     32'(MEM_CE),  32'h0);
        ck("rst_ready",  32'({IReady, DReady, BUS_ERR}), 32'h0);
        ck("rst_addr",   MEM_ADDR,     32'h0);
        ck("rst_ctl",    32'({MEM_WE, MEM_RE, MEM_BE}), 32'h0);
        reset = 0;
        @(negedge clk);

        // single fetch, READY one cycle after CE
        IReq = 1; IAddr = 32'h0000_3000;
        cyc();
        #1;
        ck("t1_be",    32'(MEM_BE), 32'hF);
        ck("t1_addr",  MEM_ADDR,    32'h0000_3000);
        ck("t1_early", 32'(IReady), 32'h0);
        cyc();
        MEM_READY = 1; MEM_DOUT = 32'h2408_0001;
        #1;
        ck("t1_iready", 32'(IReady), 32'h1);
        ck("t1_idata",  IData,       32'h2408_0001);
        cyc();
        idle_inputs();
        cyc();

        // single store with partial byte enables
        DWEn = 1; DAddr = 32'h10; DByteEn = 4'b0011; DWData = 32'hABCD; DPC = 32'h0000_0400;
        cyc();
        #1;
        ck("t2_we",  32'(MEM_WE), 32'h1);
        ck("t2_be",  32'(MEM_BE), 32'h3);
        ck("t2_din", MEM_DIN,     32'hABCD);
        ck("t2_pc",  MEM_PC,      32'h0000_0400);
        MEM_READY = 1;
        #1;
        ck("t2_dready", 32'(DReady), 32'h1);
        cyc();
        idle_inputs();
        cyc();

        // both masters saturated: grant order
        apply_reset();
        IReq = 1; IAddr = 32'h3004; DREn = 1; DAddr = 32'h20; DByteEn = 4'hF;
        MEM_READY = 1; MEM_DOUT = 32'h5555_AAAA;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (IReady || DReady) begin
                if (idx < 10) ck("t3_order", 32'(DReady), 32'(exp_order[idx]));
                idx++;
            end
            cyc();
        end
        ck("t3_grants", 32'(idx), 32'd10);
        idle_inputs();
        cyc();

        // load with no READY: timeout on the 64th BUSY cycle
        DREn = 1; DAddr = 32'h44; DByteEn = 4'hF;
        cyc();
        for (int c = 1; c <= 64; c++) begin
            #1;
            if (c == 63) ck("t4_pre_err", 32'(BUS_ERR), 32'h0);
            if (c == 64) begin
                ck("t4_dready", 32'(DReady), 32'h1);
                ck("t4_drdata", DRData,      32'h0);
                ck("t4_buserr", 32'(BUS_ERR), 32'h1);
                ck("t4_nt_err", 32'(nt_BUS_ERR), 32'h0);
                ck("t4_nt_ce",  32'(nt_MEM_CE),  32'h1);
            end
            cyc();
        end
        DREn = 0;
        #1;
        ck("t4_idle_ce", 32'(MEM_CE), 32'h0);
        cyc();

        // timeout disabled: BUSY held while READY stays low
        nt_bad = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!nt_MEM_CE || nt_BUS_ERR || nt_DReady) nt_bad = 1;
            cyc();
        end
        ck("t6_nt_held", 32'(nt_bad), 32'h0);
        MEM_READY = 1; MEM_DOUT = 32'h1234;
        #1;
        ck("t6_nt_done", 32'(nt_DReady),  32'h1);
        ck("t6_nt_data", nt_DRData,       32'h1234);
        cyc();
        idle_inputs();
        cyc();

        // READY exactly on the last pre-timeout cycle wins
        DREn = 1; DAddr = 32'h48;
        cyc();
        for (int c = 1; c < 64; c++) cyc();
        MEM_READY = 1; MEM_DOUT = 32'hCAFE;
        #1;
        ck("t6_dready", 32'(DReady),  32'h1);
        ck("t6_buserr", 32'(BUS_ERR), 32'h0);
        ck("t6_drdata", DRData,       32'hCAFE);
        cyc();
        idle_inputs();
        cyc();

        // reset mid-transaction, then a pending fetch is served normally
        DREn = 1; DAddr = 32'h80;
        cyc();
        cyc();
        IReq = 1; IAddr = 32'h3008;
        #2;
        reset = 1;
        #1;
        ck("t5_ce",    32'(MEM_CE),  32'h0);
        ck("t5_addr",  MEM_ADDR,     32'h0);
        ck("t5_ctl",   32'({MEM_WE, MEM_RE, MEM_BE, DReady, IReady, BUS_ERR}), 32'h0);
        model_clear();
        @(negedge clk);
        reset = 0; DREn = 0;
        cyc();
        #1;
        ck("t5_iaddr", MEM_ADDR,     32'h3008);
        MEM_READY = 1; MEM_DOUT = 32'h0BAD_F00D;
        #1;
        ck("t5_iready", 32'(IReady), 32'h1);
        cyc();
        idle_inputs();
        cyc();

        // randomized traffic against the memory scoreboard
        rand_mode = 1;
        for (int c = 0; c < 2000; c++) begin
            if (c < 1800) begin
                if (!i_pend && $urandom_range(0, 2) == 0) begin
                    i_pend = 1;
                    IAddr  = $urandom & 32'hFFFF_FFFC;
                end
                if (!d_pend && $urandom_range(0, 1) == 0) begin
                    d_pend  = 1;
                    kind    = $urandom_range(0, 4);
                    DREn    = (kind <= 1) || (kind == 4);
                    DWEn    = (kind >= 2);
                    DAddr   = $urandom & 32'hFFFF_FFFC;
                    DByteEn = 4'($urandom_range(1, 15));
                    DWData  = $urandom;
                    DPC     = $urandom;
                end
            end else if (!i_pend && !d_pend) begin
                break;
            end
            IReq = i_pend;
            if (!d_pend) begin
                DREn = 0; DWEn = 0;
            end
            MEM_READY = ($urandom_range(0, 2) != 0);
            MEM_DOUT  = mem_dev[MEM_ADDR[5:2]];
            cyc();
        end
        ck("rand_drained", 32'({i_pend, d_pend}), 32'h0);
        rand_mode = 0;
        idle_inputs();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
